// File: rtl/pkt_to_msg_arbiter_pkg.sv
// rtl/pkt_to_msg_arbiter_pkg.sv - NIC packet geometry and modular index helper shared by the arbiter files
package pkt_to_msg_arbiter_pkg;

    localparam int FLIT_WIDTH        = 16;
    localparam int MAX_PACKET_LENGHT = 4;
    localparam int PKT_LINK_W        = MAX_PACKET_LENGHT * FLIT_WIDTH;
    localparam int PKT_SEL_W         = MAX_PACKET_LENGHT;

    // (base + k) mod n for base < n and 1 <= k <= n; one subtraction covers the
    // wrap, so no divider is needed even for non-power-of-two n.
    function automatic int wrap_add(input int base, input int k, input int n);
        int s;
        s = base + k;
        if (s >= n) begin
            s = s - n;
        end
        return s;
    endfunction

endpackage

// File: rtl/pkt_to_msg_arbiter_if.sv
// rtl/pkt_to_msg_arbiter_if.sv - buffer-side request/payload bundle and converter-side valid/ready bundle
interface pkt_to_msg_arbiter_if #(
    parameter int N_BUFFERS = 2
) ();
    import pkt_to_msg_arbiter_pkg::*;

    localparam int N_BITS_SEL = $clog2(N_BUFFERS);

    logic [N_BUFFERS-1:0]            r_pkt_to_msg_i;
    logic [N_BUFFERS*PKT_LINK_W-1:0] out_link_i;
    logic [N_BUFFERS*PKT_SEL_W-1:0]  out_sel_i;
    logic [N_BUFFERS-1:0]            g_pkt_to_msg_o;

    logic                            pkt_valid_o;
    logic                            pkt_ready_i;
    logic [PKT_LINK_W-1:0]           pkt_link_o;
    logic [PKT_SEL_W-1:0]            pkt_sel_o;
    logic [N_BITS_SEL-1:0]           pkt_src_o;

    modport master (
        input  r_pkt_to_msg_i, out_link_i, out_sel_i, pkt_ready_i,
        output g_pkt_to_msg_o, pkt_valid_o, pkt_link_o, pkt_sel_o, pkt_src_o
    );

    modport slave (
        output r_pkt_to_msg_i, out_link_i, out_sel_i, pkt_ready_i,
        input  g_pkt_to_msg_o, pkt_valid_o, pkt_link_o, pkt_sel_o, pkt_src_o
    );

endinterface

// File: rtl/pkt_to_msg_arbiter_rr_picker.sv
// rtl/pkt_to_msg_arbiter_rr_picker.sv - combinational round-robin winner search starting after last_ptr
module rr_picker
    import pkt_to_msg_arbiter_pkg::*;
#(
    parameter int N = 2,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] last_ptr_i,
    output logic [W-1:0] winner_o,
    output logic         any_o
);

    int idx;

    // Scan from lowest to highest priority so the closest requester after
    // last_ptr is written last and wins.
    always_comb begin
        winner_o = '0;
        any_o    = 1'b0;
        idx      = 0;
        for (int k = N; k >= 1; k--) begin
            idx = wrap_add(int'(last_ptr_i), k, N);
            if (req_i[idx]) begin
                winner_o = idx[W-1:0];
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pkt_to_msg_arbiter.sv
// rtl/pkt_to_msg_arbiter.sv - shares one packet-to-message converter among per-VC flit buffers
module pkt_to_msg_arbiter
    import pkt_to_msg_arbiter_pkg::*;
#(
    parameter int N_BUFFERS  = 2,
    parameter int N_BITS_SEL = $clog2(N_BUFFERS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pkt_to_msg_arbiter_if.master bus,
    output logic                 busy_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        XFER    = 2'd1,
        RELEASE = 2'd2
    } state_e;

    localparam logic [N_BITS_SEL-1:0] LAST_PTR_RST = N_BITS_SEL'(N_BUFFERS - 1);

    state_e                state_q, state_d;
    logic [N_BITS_SEL-1:0] src_q, src_d;
    logic [N_BITS_SEL-1:0] last_ptr_q, last_ptr_d;
    logic [N_BITS_SEL-1:0] winner;
    logic                  any_req;
    logic                  src_req;
    logic                  accept;

    rr_picker #(
        .N (N_BUFFERS),
        .W (N_BITS_SEL)
    ) u_picker (
        .req_i      (bus.r_pkt_to_msg_i),
        .last_ptr_i (last_ptr_q),
        .winner_o   (winner),
        .any_o      (any_req)
    );

    // A holder that withdraws its request must never be granted, so the
    // handshake also requires the selected request to still be present.
    assign src_req = bus.r_pkt_to_msg_i[src_q];
    assign accept  = (state_q == XFER) && bus.pkt_ready_i && src_req;

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        last_ptr_d = last_ptr_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    src_d   = winner;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (!src_req) begin
                    state_d = IDLE;
                end else if (bus.pkt_ready_i) begin
                    last_ptr_d = src_q;
                    state_d    = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            src_q      <= '0;
            last_ptr_q <= LAST_PTR_RST;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            last_ptr_q <= last_ptr_d;
        end
    end

    always_comb begin
        bus.g_pkt_to_msg_o        = '0;
        bus.g_pkt_to_msg_o[src_q] = accept;
    end

    assign bus.pkt_valid_o = (state_q == XFER);
    assign bus.pkt_link_o  = bus.out_link_i[int'(src_q)*PKT_LINK_W +: PKT_LINK_W];
    assign bus.pkt_sel_o   = bus.out_sel_i[int'(src_q)*PKT_SEL_W +: PKT_SEL_W];
    assign bus.pkt_src_o   = src_q;
    assign busy_o          = (state_q != IDLE);

endmodule
